// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage ALU and the multiply/divide unit.
// Holds ALU operation codes, MDU operation codes and the MDU state encoding.
package alu_pkg;

  // ALU operation select (alu_ctr)
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  // MDU operation select (mdu_op); 11x is a no-op
  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  // MDU state encoding, kept as plain constants for compatibility with older tools
  localparam logic [1:0] MDU_IDLE = 2'b00;
  localparam logic [1:0] MDU_MUL  = 2'b01;
  localparam logic [1:0] MDU_DIVS = 2'b10;

  // Larger of the two latencies; sizes the shared down-counter
  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core: multi-cycle multiply/divide unit owning the HI/LO registers.
// A start pulse in IDLE latches the operands and loads a down-counter; the
// result is written to HI/LO on the edge where the counter is at 1.
// Optional build macro MDU_FLUSH_EN adds the mdu_flush abort input.
module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       mdu_op,
  input  logic             mdu_start,
`ifdef MDU_FLUSH_EN
  input  logic             mdu_flush,
`endif
  output logic             mdu_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(max_cycles(MUL_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_signed;
  logic               flush;

`ifdef MDU_FLUSH_EN
  assign flush = mdu_flush;
`else
  assign flush = 1'b0;
`endif

  assign mdu_busy = (state != MDU_IDLE);

  // Full-width product; operands are sign- or zero-extended to 2*WIDTH first
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  assign ext_a   = op_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
  assign ext_b   = op_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
  assign product = ext_a * ext_b;

  // Division works on magnitudes and re-applies signs, so min-int / -1
  // falls out as quotient min-int, remainder 0 without a special case
  logic             neg_a;
  logic             neg_b;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] safe_b;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  assign neg_a    = op_signed & op_a[WIDTH-1];
  assign neg_b    = op_signed & op_b[WIDTH-1];
  assign mag_a    = neg_a ? ({WIDTH{1'b0}} - op_a) : op_a;
  assign mag_b    = neg_b ? ({WIDTH{1'b0}} - op_b) : op_b;
  assign div_zero = (op_b == {WIDTH{1'b0}});
  assign safe_b   = div_zero ? ONE : mag_b;
  assign quo_mag  = mag_a / safe_b;
  assign rem_mag  = mag_a % safe_b;
  assign quo      = (neg_a ^ neg_b) ? ({WIDTH{1'b0}} - quo_mag) : quo_mag;
  assign rem      = neg_a ? ({WIDTH{1'b0}} - rem_mag) : rem_mag;
  assign div_lo   = div_zero ? {WIDTH{1'b1}} : quo;
  assign div_hi   = div_zero ? op_a : rem;

  // FSM: accept ops in IDLE, count down while busy, commit HI/LO on the last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MDU_IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (mdu_start && !flush) begin
            case (mdu_op)
              MDU_MULT, MDU_MULTU: begin
                op_a      <= in1;
                op_b      <= in2;
                op_signed <= ~mdu_op[0];
                state     <= MDU_MUL;
                cnt       <= CNT_W'(MUL_CYCLES);
              end
              MDU_DIV, MDU_DIVU: begin
                op_a      <= in1;
                op_b      <= in2;
                op_signed <= ~mdu_op[0];
                state     <= MDU_DIVS;
                cnt       <= CNT_W'(DIV_CYCLES);
              end
              MDU_MTHI: hi <= in1;
              MDU_MTLO: lo <= in1;
              default: ;
            endcase
          end
        end
        MDU_MUL, MDU_DIVS: begin
          if (flush) begin
            state <= MDU_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_ONE) begin
            if (state == MDU_MUL) begin
              hi <= product[2*WIDTH-1:WIDTH];
              lo <= product[WIDTH-1:0];
            end else begin
              hi <= div_hi;
              lo <= div_lo;
            end
            state <= MDU_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= MDU_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage unit with a combinational ALU beside the multi-cycle MDU.
// Optional build macro MDU_FLUSH_EN exposes mdu_flush to abort an in-flight op.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_ctr,
  output logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       mdu_op,
  input  logic             mdu_start,
`ifdef MDU_FLUSH_EN
  input  logic             mdu_flush,
`endif
  output logic             mdu_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic           slt_res;
  logic           sltu_res;

  assign shamt    = in1[SHW-1:0];
  assign slt_res  = ($signed(in1) < $signed(in2));
  assign sltu_res = (in1 < in2);

  // ALU result select; unknown codes drive zero
  always_comb begin
    alu_out = '0;
    case (alu_ctr)
      ALU_ADD:  alu_out = in1 + in2;
      ALU_SUB:  alu_out = in1 - in2;
      ALU_OR:   alu_out = in1 | in2;
      ALU_AND:  alu_out = in1 & in2;
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, slt_res};
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, sltu_res};
      ALU_XOR:  alu_out = in1 ^ in2;
      ALU_NOR:  alu_out = ~(in1 | in2);
      ALU_SLL:  alu_out = in2 << shamt;
      ALU_SRL:  alu_out = in2 >> shamt;
      ALU_SRA:  alu_out = $signed(in2) >>> shamt;
      ALU_LUI:  alu_out = in2 << (WIDTH / 2);
      default:  alu_out = '0;
    endcase
  end

  mdu_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .mdu_op    (mdu_op),
    .mdu_start (mdu_start),
`ifdef MDU_FLUSH_EN
    .mdu_flush (mdu_flush),
`endif
    .mdu_busy  (mdu_busy),
    .hi        (hi),
    .lo        (lo)
  );

endmodule
